pattern_detector_param: RTL and testbench

Parametrised Moore serial-pattern detector, successor to the fixed "01" detector. It matches a runtime-loadable bit pattern of 1..MAX_LEN bits on a qualified serial input. Overlapping and non-overlapping detection are selectable. A saturating match counter is included. It sits on serial front-ends as the framing/sync-word detector.

---
 rtl/pattern_detector_param.sv | 133 +++++++++++++
 tb/tb_pattern_detector_param.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_detector_param.sv
// Parametrised Moore serial-pattern detector.
// Matches a runtime-loadable pattern of 1..MAX_LEN bits on a qualified serial
// input, with selectable overlapping / non-overlapping detection and a
// saturating match counter.
module pattern_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               a,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_count,
  output logic               y,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SCAN  = 2'd1,
    MATCH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               state, state_next;
  logic [MAX_LEN-1:0]   hist, hist_next;
  logic [LEN_W-1:0]     fill, base, nfill;
  logic [LEN_W:0]       base_inc;
  logic [MAX_LEN-1:0]   pattern;
  logic [LEN_W-1:0]     len;
  logic                 overlap;
  logic [MAX_LEN-1:0]   mask;
  logic                 consume, full, hit;
  logic [LEN_W-1:0]     cfg_len_clamped;

  // Sample qualification, fill tracking and pattern compare against the
  // history as it will look after this sample.
  always_comb begin
    consume   = en && !cfg_load;
    hist_next = {hist[MAX_LEN-2:0], a};
    // Non-overlapping mode forgets the history once a match has been reported.
    base      = (state == MATCH && !overlap) ? '0 : fill;
    base_inc  = {1'b0, base} + {{LEN_W{1'b0}}, 1'b1};
    nfill     = (base_inc >= {1'b0, len}) ? len : base_inc[LEN_W-1:0];
    full      = (nfill == len);
    mask      = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < 32'(len));
    end
    hit       = consume && full && (((hist_next ^ pattern) & mask) == '0);
  end

  // Length clamp for loaded configuration: 0 -> 1, above MAX_LEN -> MAX_LEN.
  always_comb begin
    cfg_len_clamped = cfg_len;
    if (cfg_len == '0) begin
      cfg_len_clamped = LEN_W'(1);
    end else if (cfg_len > LEN_W'(MAX_LEN)) begin
      cfg_len_clamped = LEN_W'(MAX_LEN);
    end
  end

  // Next-state selection; a load always restarts from an empty history.
  always_comb begin
    state_next = state;
    if (cfg_load) begin
      state_next = FILL;
    end else if (en) begin
      if (hit) begin
        state_next = MATCH;
      end else if (full) begin
        state_next = SCAN;
      end else begin
        state_next = FILL;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // History, fill count and configuration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist    <= '0;
      fill    <= '0;
      pattern <= '0;
      len     <= LEN_W'(1);
      overlap <= 1'b1;
    end else if (cfg_load) begin
      hist    <= '0;
      fill    <= '0;
      pattern <= cfg_pattern;
      len     <= cfg_len_clamped;
      overlap <= cfg_overlap;
    end else if (en) begin
      hist <= hist_next;
      fill <= nfill;
    end
  end

  // Saturating match counter; a clear coincident with a hit counts that hit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (clr_count) begin
      match_count <= hit ? CNT_W'(1) : '0;
      count_sat   <= 1'b0;
    end else if (hit && match_count != CNT_MAX) begin
      match_count <= match_count + CNT_W'(1);
      if (match_count == CNT_MAX - CNT_W'(1)) begin
        count_sat <= 1'b1;
      end
    end
  end

  assign y = (state == MATCH);

endmodule

// File: tb/tb_pattern_detector_param.sv
// Directed self-checking bench for pattern_detector_param (MAX_LEN=8, CNT_W=4).
module tb_pattern_detector_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk;
  logic               reset_n;
  logic               en;
  logic               a;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               clr_count;
  logic               y;
  logic [CNT_W-1:0]   match_count;
  logic               count_sat;

  int n_checks = 0;
  int n_fail   = 0;

  pattern_detector_param #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .a          (a),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .clr_count  (clr_count),
    .y          (y),
    .match_count(match_count),
    .count_sat  (count_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given en/a; returns 1 time unit after the edge.
  task automatic sample(input logic ai, input logic ei);
    a  = ai;
    en = ei;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] ln,
                      input logic ov, input logic ei, input logic ai);
    cfg_pattern = pat;
    cfg_len     = ln;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    en          = ei;
    a           = ai;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    en       = 1'b0;
  endtask

  task automatic clear_count();
    clr_count = 1'b1;
    en        = 1'b0;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (y !== 1'b0 || match_count !== 4'd0 || count_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: y=%b cnt=%0d sat=%b expected y=0 cnt=0 sat=0", y, match_count, count_sat);
    end
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    // Default configuration after reset is len=1, pattern=0.
    sample(1'b0, 1'b1);
    n_checks++;
    if (y !== 1'b1 || match_count !== 4'd1) begin
      n_fail++;
      $display("FAIL reset_default_cfg: y=%b cnt=%0d expected y=1 cnt=1", y, match_count);
    end
  endtask

  task automatic test_legacy_01();
    logic [4:0] stim;
    logic [4:0] exp_y;
    stim  = 5'b10101;   // bit 4 first
    exp_y = 5'b00101;
    clear_count();
    load(8'b01, 4'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 4; i >= 0; i--) begin
      sample(stim[i], 1'b1);
      n_checks++;
      if (y !== exp_y[i]) begin
        n_fail++;
        $display("FAIL legacy01_y sample %0d: got %b expected %b", 5 - i, y, exp_y[i]);
      end
    end
    n_checks++;
    if (match_count !== 4'd2) begin
      n_fail++;
      $display("FAIL legacy01_count: got %0d expected 2", match_count);
    end
  endtask

  task automatic test_overlap();
    logic [4:0] stim;
    logic [4:0] exp_ov;
    logic [4:0] exp_nov;
    stim    = 5'b10101;
    exp_ov  = 5'b00101;
    exp_nov = 5'b00100;
    for (int m = 1; m >= 0; m--) begin
      clear_count();
      load(8'b101, 4'd3, m[0], 1'b0, 1'b0);
      for (int i = 4; i >= 0; i--) begin
        sample(stim[i], 1'b1);
        n_checks++;
        if (y !== (m[0] ? exp_ov[i] : exp_nov[i])) begin
          n_fail++;
          $display("FAIL overlap%0d_y sample %0d: got %b expected %b", m, 5 - i, y,
                   m[0] ? exp_ov[i] : exp_nov[i]);
        end
      end
      n_checks++;
      if (match_count !== (m[0] ? 4'd2 : 4'd1)) begin
        n_fail++;
        $display("FAIL overlap%0d_count: got %0d expected %0d", m, match_count, m[0] ? 2 : 1);
      end
    end
  endtask

  task automatic test_en_gating();
    clear_count();
    load(8'b01, 4'd2, 1'b1, 1'b0, 1'b0);
    sample(1'b0, 1'b1);
    sample(1'b1, 1'b0);
    sample(1'b1, 1'b0);
    sample(1'b0, 1'b0);
    n_checks++;
    if (y !== 1'b0) begin
      n_fail++;
      $display("FAIL en_idle_no_match: got y=%b expected 0", y);
    end
    sample(1'b1, 1'b1);
    n_checks++;
    if (y !== 1'b1) begin
      n_fail++;
      $display("FAIL en_match: got y=%b expected 1", y);
    end
    for (int i = 0; i < 4; i++) begin
      sample(i[0], 1'b0);
      n_checks++;
      if (y !== 1'b1) begin
        n_fail++;
        $display("FAIL en_hold_y idle %0d: got %b expected 1", i, y);
      end
    end
    sample(1'b0, 1'b1);
    n_checks++;
    if (y !== 1'b0 || match_count !== 4'd1) begin
      n_fail++;
      $display("FAIL en_drop: y=%b cnt=%0d expected y=0 cnt=1", y, match_count);
    end
  endtask

  task automatic test_saturation();
    clear_count();
    load(8'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      sample(1'b1, 1'b1);
      if (i == 14) begin
        n_checks++;
        if (match_count !== 4'd14 || count_sat !== 1'b0) begin
          n_fail++;
          $display("FAIL sat_before: cnt=%0d sat=%b expected cnt=14 sat=0", match_count, count_sat);
        end
      end
      if (i == 15) begin
        n_checks++;
        if (match_count !== 4'd15 || count_sat !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_reach: cnt=%0d sat=%b expected cnt=15 sat=1", match_count, count_sat);
        end
      end
    end
    n_checks++;
    if (match_count !== 4'd15 || count_sat !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_hold: cnt=%0d sat=%b expected cnt=15 sat=1", match_count, count_sat);
    end
    clr_count = 1'b1;
    sample(1'b1, 1'b1);
    clr_count = 1'b0;
    n_checks++;
    if (match_count !== 4'd1 || count_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_with_hit: cnt=%0d sat=%b expected cnt=1 sat=0", match_count, count_sat);
    end
  endtask

  task automatic test_cfg_edges();
    logic [7:0] seq;
    // cfg_len=0 behaves as len=1.
    clear_count();
    load(8'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    sample(1'b1, 1'b1);
    n_checks++;
    if (y !== 1'b1) begin
      n_fail++;
      $display("FAIL len0_match: got y=%b expected 1", y);
    end
    sample(1'b0, 1'b1);
    n_checks++;
    if (y !== 1'b0 || match_count !== 4'd1) begin
      n_fail++;
      $display("FAIL len0_nomatch: y=%b cnt=%0d expected y=0 cnt=1", y, match_count);
    end
    // Oversized length clamps to MAX_LEN.
    seq = 8'hA5;
    load(seq, 4'(MAX_LEN + 3), 1'b1, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      sample(seq[i], 1'b1);
      n_checks++;
      if (y !== (i == 0)) begin
        n_fail++;
        $display("FAIL clamp_y sample %0d: got %b expected %b", 8 - i, y, i == 0);
      end
    end
    // Sample presented with cfg_load is discarded.
    load(8'b01, 4'd2, 1'b1, 1'b1, 1'b0);
    sample(1'b1, 1'b1);
    n_checks++;
    if (y !== 1'b0) begin
      n_fail++;
      $display("FAIL load_discard: got y=%b expected 0", y);
    end
    sample(1'b0, 1'b1);
    sample(1'b1, 1'b1);
    n_checks++;
    if (y !== 1'b1) begin
      n_fail++;
      $display("FAIL load_after_discard: got y=%b expected 1", y);
    end
    // Unused high pattern bits are ignored.
    load(8'hFD, 4'd2, 1'b1, 1'b0, 1'b0);
    sample(1'b0, 1'b1);
    sample(1'b1, 1'b1);
    n_checks++;
    if (y !== 1'b1) begin
      n_fail++;
      $display("FAIL high_bits_ignored: got y=%b expected 1", y);
    end
  endtask

  task automatic test_reset_midstream();
    clear_count();
    load(8'b01, 4'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample(1'b0, 1'b1);
      sample(1'b1, 1'b1);
    end
    n_checks++;
    if (y !== 1'b1 || match_count !== 4'd3) begin
      n_fail++;
      $display("FAIL pre_reset: y=%b cnt=%0d expected y=1 cnt=3", y, match_count);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (y !== 1'b0 || match_count !== 4'd0 || count_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: y=%b cnt=%0d sat=%b expected 0/0/0", y, match_count, count_sat);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    sample(1'b0, 1'b1);
    n_checks++;
    if (y !== 1'b1 || match_count !== 4'd1) begin
      n_fail++;
      $display("FAIL post_reset_default: y=%b cnt=%0d expected y=1 cnt=1", y, match_count);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    en          = 1'b0;
    a           = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    clr_count   = 1'b0;
    test_reset();
    test_legacy_01();
    test_overlap();
    test_en_gating();
    test_saturation();
    test_cfg_edges();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
